// File: rtl/ssd1306_tx_arbiter.sv
// ssd1306_tx_arbiter: shares one SPI byte master between the command path (DC=0) and the pixel streamer (DC=1).
// Optional WAIT watchdog: define SSD1306_ARB_TIMEOUT_EN to enable the timeout counter and err_timeout.
module ssd1306_tx_arbiter #(
    parameter int MAX_BURST      = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_byte,
    output logic        cmd_ready,
    input  logic        pix_valid,
    input  logic [7:0]  pix_byte,
    input  logic        pix_lock,
    output logic        pix_ready,
    output logic [7:0]  spi_data,
    output logic        spi_wr,
    input  logic        spi_done,
    output logic        oled_dc,
    output logic        busy,
    output logic [1:0]  grant,
    output logic [15:0] tx_count,
    output logic        err_timeout
);

    // state  | meaning
    // S_IDLE | nothing in flight; arbitrate and latch the winning byte
    // S_LOAD | one cycle: spi_wr plus the winner's ready pulse
    // S_WAIT | byte on the wire, waiting for spi_done
    // S_GAP  | inter-byte spacing after completion
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          dc_q, dc_d;
    logic [1:0]    grant_q, grant_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          last_pix_q, last_pix_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   tx_count_q, tx_count_d;

`ifdef SSD1306_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_q, to_d;
    logic          err_q, err_d;
`endif

    logic pix_keep;
    logic take_pix;
    logic finish;

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            dc_q       <= 1'b0;
            grant_q    <= '0;
            burst_q    <= '0;
            last_pix_q <= 1'b0;
            gap_q      <= '0;
            tx_count_q <= '0;
`ifdef SSD1306_ARB_TIMEOUT_EN
            to_q       <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            dc_q       <= dc_d;
            grant_q    <= grant_d;
            burst_q    <= burst_d;
            last_pix_q <= last_pix_d;
            gap_q      <= gap_d;
            tx_count_q <= tx_count_d;
`ifdef SSD1306_ARB_TIMEOUT_EN
            to_q       <= to_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        dc_d       = dc_q;
        grant_d    = grant_q;
        burst_d    = burst_q;
        last_pix_d = last_pix_q;
        gap_d      = gap_q;
        tx_count_d = tx_count_q;
        finish     = 1'b0;
        take_pix   = 1'b0;
`ifdef SSD1306_ARB_TIMEOUT_EN
        to_d       = to_q;
        err_d      = err_q;
`endif

        // a locked pixel stream keeps the bus until its burst allowance runs out
        pix_keep = pix_valid && last_pix_q && pix_lock && (burst_q < BURST_MAX);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid || pix_valid) begin
                    take_pix   = pix_valid && (pix_keep || !cmd_valid);
                    data_d     = take_pix ? pix_byte : cmd_byte;
                    dc_d       = take_pix;
                    grant_d    = take_pix ? 2'b10 : 2'b01;
                    last_pix_d = take_pix;
                    if (take_pix) begin
                        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
                    end else begin
                        burst_d = '0;
                    end
                    state_d = S_LOAD;
`ifdef SSD1306_ARB_TIMEOUT_EN
                    to_d = TO_LOAD;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
`ifdef SSD1306_ARB_TIMEOUT_EN
                if (to_q != '0) begin
                    to_d = to_q - 1'b1;
                end
`endif
            end
            S_WAIT: begin
                if (spi_done) begin
                    tx_count_d = tx_count_q + 16'd1;
                    finish     = 1'b1;
`ifdef SSD1306_ARB_TIMEOUT_EN
                end else if (to_q == '0) begin
                    err_d  = 1'b1;
                    finish = 1'b1;
                end else begin
                    to_d = to_q - 1'b1;
`endif
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (finish) begin
            if (GAP_CYCLES > 0) begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end else begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        end
    end

    assign spi_wr    = (state_q == S_LOAD);
    assign cmd_ready = spi_wr && grant_q[0];
    assign pix_ready = spi_wr && grant_q[1];
    assign busy      = (state_q != S_IDLE);
    assign spi_data  = data_q;
    assign oled_dc   = dc_q;
    assign grant     = grant_q;
    assign tx_count  = tx_count_q;
`ifdef SSD1306_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ssd1306_tx_arbiter.sv
// Bench for ssd1306_tx_arbiter: transfer-level reference model checked every cycle plus literal byte-order checks.
module tb_ssd1306_tx_arbiter;

    localparam int MB  = 4;
    localparam int GAP = 2;
    localparam int TO  = 16;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_byte = 8'h00;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_byte = 8'h00;
    logic        pix_lock = 1'b0;
    logic        spi_done = 1'b0;
    logic        cmd_ready, pix_ready, spi_wr, oled_dc, busy, err_timeout;
    logic [7:0]  spi_data;
    logic [1:0]  grant;
    logic [15:0] tx_count;

    ssd1306_tx_arbiter #(.MAX_BURST(MB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
        .pix_valid(pix_valid), .pix_byte(pix_byte), .pix_lock(pix_lock), .pix_ready(pix_ready),
        .spi_data(spi_data), .spi_wr(spi_wr), .spi_done(spi_done), .oled_dc(oled_dc),
        .busy(busy), .grant(grant), .tx_count(tx_count), .err_timeout(err_timeout)
    );

    always #10 clk_50M = ~clk_50M;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: one transfer record (grant cycle, completion cycle, end of gap)
    bit          m_init = 0, m_busy = 0, m_done = 0, m_dc = 0, m_last_pix = 0, m_err = 0, take_pix = 0;
    int          m_k = -100, m_end = -100, m_owner = 0, m_burst = 0;
    logic [7:0]  m_byte = 8'h00;
    logic [15:0] m_count = 16'h0000;
    bit          force_on = 0;

    always @(posedge clk_50M) begin
        cyc++;
        if (!rst_n) begin
            m_init = 1; m_busy = 0; m_done = 0; m_owner = 0; m_byte = 8'h00; m_dc = 0;
            m_count = 16'h0000; m_err = 0; m_last_pix = 0; m_burst = 0;
        end else if (m_init) begin
            if (force_on) m_count = 16'hFFFF;
            if (!m_busy) begin
                if (cmd_valid || pix_valid) begin
                    take_pix = pix_valid && ((m_last_pix && pix_lock && m_burst < MB) || !cmd_valid);
                    m_busy = 1; m_done = 0; m_k = cyc;
                    m_owner = take_pix ? 2 : 1;
                    m_byte = take_pix ? pix_byte : cmd_byte;
                    m_dc = take_pix;
                    m_last_pix = take_pix;
                    m_burst = take_pix ? ((m_burst < MB) ? m_burst + 1 : m_burst) : 0;
                end
            end else begin
                if (!m_done) begin
                    if (spi_done && cyc >= m_k + 2) begin
                        m_done = 1; m_count = m_count + 16'd1; m_end = cyc + GAP;
                    end
`ifdef SSD1306_ARB_TIMEOUT_EN
                    else if (cyc == m_k + TO) begin
                        m_done = 1; m_err = 1; m_end = cyc + GAP;
                    end
`endif
                end
                if (m_done && cyc == m_end) begin
                    m_busy = 0; m_owner = 0;
                end
            end
        end
    end

    logic [8:0] wr_log[$];
    int last_wr_cyc = 0, idle_cyc = 0, cmd_rdy_n = 0, wr_n = 0;
    bit prev_busy = 0;

    always @(negedge clk_50M) begin
        if (m_init) begin
            chk("busy", 16'(busy), 16'(m_busy));
            chk("spi_wr", 16'(spi_wr), 16'(m_busy && cyc == m_k));
            chk("cmd_ready", 16'(cmd_ready), 16'(m_busy && cyc == m_k && m_owner == 1));
            chk("pix_ready", 16'(pix_ready), 16'(m_busy && cyc == m_k && m_owner == 2));
            chk("grant", 16'(grant), (m_owner == 2) ? 16'd2 : ((m_owner == 1) ? 16'd1 : 16'd0));
            chk("spi_data", 16'(spi_data), 16'(m_byte));
            chk("oled_dc", 16'(oled_dc), 16'(m_dc));
            if (!force_on) chk("tx_count", tx_count, m_count);
            chk("err_timeout", 16'(err_timeout), 16'(m_err));
        end
        if (spi_wr === 1'b1) begin
            wr_log.push_back({oled_dc, spi_data});
            last_wr_cyc = cyc;
            wr_n++;
        end
        if (cmd_ready === 1'b1) cmd_rdy_n++;
        if (prev_busy && busy === 1'b0) idle_cyc = cyc;
        prev_busy = (busy === 1'b1);
    end

    // SPI master stand-in: pulses spi_done done_lat cycles after each spi_wr
    int done_lat = 3;
    bit resp_en = 1;
    initial begin
        forever begin
            @(negedge clk_50M);
            if (spi_wr === 1'b1 && resp_en) begin
                repeat (done_lat) @(negedge clk_50M);
                spi_done = 1'b1;
                @(negedge clk_50M);
                spi_done = 1'b0;
            end
        end
    end

    task automatic serve(input int n_pix, input logic [7:0] pix_base, input logic lock,
                         input int n_cmd, input logic [7:0] cmd_base, input int cmd_after, input int lat);
        int pi = 0;
        int ci = 0;
        int budget = 0;
        bit cmd_on = 0;
        done_lat = lat;
        pix_lock = lock;
        if (n_pix > 0) begin pix_valid = 1'b1; pix_byte = pix_base; end
        if (n_cmd > 0 && cmd_after == 0) begin cmd_valid = 1'b1; cmd_byte = cmd_base; cmd_on = 1; end
        while ((pi < n_pix || ci < n_cmd || busy !== 1'b0) && budget < 2000) begin
            @(negedge clk_50M);
            budget++;
            if (pix_ready === 1'b1) begin
                pi++;
                if (pi < n_pix) pix_byte = pix_base + 8'(pi); else pix_valid = 1'b0;
            end
            if (cmd_ready === 1'b1) begin
                ci++;
                if (ci < n_cmd) cmd_byte = cmd_base + 8'(ci); else cmd_valid = 1'b0;
            end
            if (!cmd_on && n_cmd > 0 && pi >= cmd_after) begin
                cmd_valid = 1'b1; cmd_byte = cmd_base; cmd_on = 1;
            end
        end
        chk("serve_in_budget", 16'(budget < 2000), 16'd1);
        pix_lock = 1'b0;
        repeat (2) @(negedge clk_50M);
    endtask

    task automatic wait_cmd_ready(input string name);
        int b = 0;
        while (cmd_ready !== 1'b1 && b < 100) begin
            @(negedge clk_50M);
            b++;
        end
        chk(name, 16'(cmd_ready === 1'b1), 16'd1);
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (busy !== 1'b0 && b < 200) begin
            @(negedge clk_50M);
            b++;
        end
        chk(name, 16'(busy === 1'b0), 16'd1);
    endtask

    logic [8:0] exp4 [7] = '{9'h110, 9'h111, 9'h112, 9'h113, 9'h03C, 9'h114, 9'h115};
    int base;
    int k;

    initial begin
        repeat (3) @(negedge clk_50M);
        chk("rst_tx_count", tx_count, 16'h0000);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;
        @(negedge clk_50M);

        // single command byte, done 5 cycles after spi_wr
        base = wr_log.size();
        serve(0, 8'h00, 1'b0, 1, 8'hAE, 0, 5);
        chk("t2_byte", 16'(wr_log[base]), 16'h00AE);
        chk("t2_tx_count", tx_count, 16'd1);
        chk("t2_ready_pulses", 16'(cmd_rdy_n), 16'd1);
        chk("t2_wr_pulses", 16'(wr_n), 16'd1);
        chk("t2_busy_low_after", 16'(idle_cyc - last_wr_cyc), 16'd8);

        // locked pixel burst preempted by a command after MAX_BURST grants
        base = wr_log.size();
        serve(6, 8'h10, 1'b1, 1, 8'h3C, 1, 3);
        for (int i = 0; i < 7; i++) chk($sformatf("t4_order%0d", i), 16'(wr_log[base + i]), 16'(exp4[i]));
        chk("t4_tx_count", tx_count, 16'd8);

        // simultaneous requests without lock: command first
        base = wr_log.size();
        serve(1, 8'h55, 1'b0, 1, 8'h81, 0, 2);
        chk("t3_first", 16'(wr_log[base]), 16'h0081);
        chk("t3_second", 16'(wr_log[base + 1]), 16'h0155);

        // reset while a byte is in WAIT; its late spi_done must be ignored
        done_lat = 10;
        cmd_valid = 1'b1; cmd_byte = 8'h42;
        wait_cmd_ready("t1_ready_seen");
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk_50M);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        chk("t1_rst_busy", 16'(busy), 16'd0);
        chk("t1_rst_grant", 16'(grant), 16'd0);
        chk("t1_rst_data", 16'(spi_data), 16'd0);
        chk("t1_rst_count", tx_count, 16'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk_50M);
        chk("t1_late_done_count", tx_count, 16'd0);
        chk("t1_late_done_busy", 16'(busy), 16'd0);

        // tx_count wrap
        force_on = 1;
        force dut.tx_count_q = 16'hFFFF;
        @(negedge clk_50M);
        release dut.tx_count_q;
        force_on = 0;
        @(negedge clk_50M);
        chk("t5_preset", tx_count, 16'hFFFF);
        base = wr_log.size();
        serve(0, 8'h00, 1'b0, 1, 8'hA5, 0, 3);
        chk("t5_byte", 16'(wr_log[base]), 16'h00A5);
        chk("t5_wrap", tx_count, 16'h0000);

`ifdef SSD1306_ARB_TIMEOUT_EN
        resp_en = 0;
        cmd_valid = 1'b1; cmd_byte = 8'h99;
        wait_cmd_ready("t6_ready_seen");
        k = cyc;
        cmd_valid = 1'b0;
        repeat (TO - 1) @(negedge clk_50M);
        chk("t6_err_before", 16'(err_timeout), 16'd0);
        @(negedge clk_50M);
        chk("t6_err_at", 16'(err_timeout), 16'd1);
        chk("t6_err_cycle", 16'(cyc - k), 16'(TO));
        wait_idle("t6_back_idle");
        chk("t6_count_unchanged", tx_count, 16'h0000);
        resp_en = 1;
        base = wr_log.size();
        serve(0, 8'h00, 1'b0, 1, 8'h77, 0, 2);
        chk("t6_next_byte", 16'(wr_log[base]), 16'h0077);
        chk("t6_next_count", tx_count, 16'h0001);
        chk("t6_err_sticky", 16'(err_timeout), 16'd1);
`else
        k = cyc;
        chk("t6_err_tied", 16'(err_timeout), 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
